eq_self_test: RTL
=================

EQ_SELF_TEST -- requirements
Module: eq_self_test

Interface
REQ-001 Parameters (name, default, meaning), one per line; the block SHALL provide exactly these:
  WIDTH  1  operand width driven to the comparator under test (1..4).
  HOLD_CYCLES  20  clock cycles each pattern is held (>=1); 20 at 10 ns clk = 200 ns.
REQ-002 Ports (name, direction, width, meaning), one per line; the block SHALL provide exactly these:
  clk  in  1  single clock, rising edge.
  reset  in  1  synchronous, active-high reset.
  start  in  1  one-cycle request to run a full sweep.
  eq_in  in  1  equality result returned by the comparator under test.
  i0  out  WIDTH  operand A driven to the comparator.
  i1  out  WIDTH  operand B driven to the comparator.
  busy  out  1  sweep in progress.
  done  out  1  sweep complete; results valid.
  pass  out  1  1 when done and err_count==0.
  err_count  out  8  number of mismatching patterns, saturating.
  fail_i0  out  WIDTH  i0 of the first failing pattern.
  fail_i1  out  WIDTH  i1 of the first failing pattern.
REQ-003 The block SHALL use one clock (clk) with a synchronous, active-high reset (reset); all state SHALL change only on rising clk.

Function
REQ-004 FSM states SHALL be IDLE, APPLY and DONE; no other reachable states.
REQ-005 IDLE: i0=i1=0, busy=0, done=0; start=1 -> APPLY with idx=0, hold=HOLD_CYCLES-1, err_count=0, fail_i0=fail_i1=0, first-fail flag cleared.
REQ-006 Pattern index idx SHALL be 2*WIDTH bits; in APPLY, i0=idx[2*WIDTH-1:WIDTH] and i1=idx[WIDTH-1:0], so order is 00,01,10,11 for WIDTH=1.
REQ-007 APPLY: hold SHALL decrement every cycle while nonzero; each pattern SHALL be driven for exactly HOLD_CYCLES cycles.
REQ-008 On the edge where hold==0, eq_in SHALL be compared against expected (i0==i1); a mismatch SHALL increment err_count, saturating at 255.
REQ-009 On the first mismatch of a sweep, fail_i0/fail_i1 SHALL capture the current i0/i1; later mismatches SHALL NOT overwrite them.
REQ-010 On the same edge, if idx is not all-ones, idx SHALL increment and hold SHALL reload HOLD_CYCLES-1; otherwise the state SHALL go to DONE.
REQ-011 busy SHALL be 1 exactly while in APPLY; start while busy SHALL be ignored.
REQ-012 DONE: done=1, i0=i1=0, pass=(err_count==0); results SHALL hold until reset or start.
REQ-013 start in DONE SHALL behave as in REQ-005: clear results and enter APPLY on the same edge.
REQ-014 eq_in SHALL be sampled only on compare edges; its value at all other times SHALL have no effect.
REQ-015 pass SHALL be 0 whenever done=0.

Reset
REQ-016 reset=1 at a rising edge SHALL force IDLE, idx=0, hold=0, i0=i1=0, busy=0, done=0, pass=0, err_count=0, fail_i0=fail_i1=0, from any state.
REQ-017 Reset mid-sweep SHALL abandon the sweep; a new start SHALL be required; reset SHALL take priority over start.

Verification
REQ-018 WIDTH=1, HOLD_CYCLES=4, ideal comparator model, start at edge E0 -> patterns 00/01/10/11 each held 4 cycles; done=1 after E16; pass=1; err_count=0.
REQ-019 WIDTH=1, HOLD_CYCLES=4, eq_in stuck at 0 -> err_count=2, fail_i0=0, fail_i1=0, pass=0.
REQ-020 WIDTH=1, HOLD_CYCLES=4, inverted comparator -> err_count=4, first failure 00; second start in DONE clears results and reruns with the same result.
REQ-021 WIDTH=4, HOLD_CYCLES=1, inverted comparator -> 256 mismatches; err_count saturates at 255; fail_i0=fail_i1=0.
REQ-022 Reset asserted at cycle 6 of a sweep -> next cycle: all outputs at reset values; start pulse during busy ignored; a fresh start completes normally.

Source files
------------

// File: rtl/eq_self_test.sv
// Built-in self test for an equality comparator: sweeps every {i0,i1} operand pair,
// holds each for HOLD_CYCLES clocks, then scores the returned eq_in against i0==i1.
module eq_self_test #(
  parameter int WIDTH       = 1,
  parameter int HOLD_CYCLES = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             eq_in,
  output logic [WIDTH-1:0] i0,
  output logic [WIDTH-1:0] i1,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [7:0]       err_count,
  output logic [WIDTH-1:0] fail_i0,
  output logic [WIDTH-1:0] fail_i1
);

  localparam int IW = 2 * WIDTH;
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_RELOAD = HW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          r_state;
  logic [IW-1:0]   r_idx;
  logic [HW-1:0]   r_hold;
  logic            r_first;
  logic [WIDTH-1:0] r_i0, r_i1, r_fail_i0, r_fail_i1;
  logic            r_busy, r_done, r_pass;
  logic [7:0]      r_err;

  logic            w_start_ok;
  logic            w_cmp;
  logic            w_mismatch;
  logic [7:0]      w_err_nxt;
  logic [IW-1:0]   w_idx_nxt;
  logic            w_last;

  // start is honoured only outside a sweep; eq_in only matters on the compare edge
  assign w_start_ok = start && (r_state != APPLY);
  assign w_cmp      = (r_state == APPLY) && (r_hold == '0);
  assign w_mismatch = w_cmp && (eq_in != (r_i0 == r_i1));
  assign w_err_nxt  = (w_mismatch && (r_err != 8'hFF)) ? r_err + 8'd1 : r_err;
  assign w_idx_nxt  = r_idx + IW'(1);
  assign w_last     = (r_idx == '1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_idx     <= '0;
      r_hold    <= '0;
      r_first   <= 1'b0;
      r_i0      <= '0;
      r_i1      <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_pass    <= 1'b0;
      r_err     <= '0;
      r_fail_i0 <= '0;
      r_fail_i1 <= '0;
    end else if (w_start_ok) begin
      r_state   <= APPLY;
      r_idx     <= '0;
      r_hold    <= HOLD_RELOAD;
      r_first   <= 1'b0;
      r_i0      <= '0;
      r_i1      <= '0;
      r_busy    <= 1'b1;
      r_done    <= 1'b0;
      r_pass    <= 1'b0;
      r_err     <= '0;
      r_fail_i0 <= '0;
      r_fail_i1 <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_i0   <= '0;
          r_i1   <= '0;
          r_busy <= 1'b0;
          r_done <= 1'b0;
          r_pass <= 1'b0;
        end
        APPLY: begin
          if (r_hold != '0) begin
            r_hold <= r_hold - HW'(1);
          end else begin
            r_err <= w_err_nxt;
            if (w_mismatch && !r_first) begin
              r_first   <= 1'b1;
              r_fail_i0 <= r_i0;
              r_fail_i1 <= r_i1;
            end
            if (!w_last) begin
              r_idx  <= w_idx_nxt;
              r_hold <= HOLD_RELOAD;
              r_i0   <= w_idx_nxt[IW-1:WIDTH];
              r_i1   <= w_idx_nxt[WIDTH-1:0];
            end else begin
              r_state <= DONE;
              r_i0    <= '0;
              r_i1    <= '0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_pass  <= (w_err_nxt == 8'd0);
            end
          end
        end
        DONE: begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_pass  <= 1'b0;
        end
      endcase
    end
  end

  assign i0        = r_i0;
  assign i1        = r_i1;
  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign err_count = r_err;
  assign fail_i0   = r_fail_i0;
  assign fail_i1   = r_fail_i1;

endmodule
